// File: rtl/pb_debouncer_if.sv
// Pushbutton conditioner signal bundle: raw button inputs toward the
// debouncer and clean levels/press pulses back toward the game latch.
interface pb_debouncer_if;
    logic pbl_raw;
    logic pbr_raw;
    logic pbl;
    logic pbr;
    logic pbl_press;
    logic pbr_press;

    // Button side: drives raw contacts and consumes conditioned outputs.
    modport master (
        output pbl_raw,
        output pbr_raw,
        input  pbl,
        input  pbr,
        input  pbl_press,
        input  pbr_press
    );

    // Debouncer side.
    modport slave (
        input  pbl_raw,
        input  pbr_raw,
        output pbl,
        output pbr,
        output pbl_press,
        output pbr_press
    );
endinterface

// File: rtl/pb_debouncer.sv
// Two-channel pushbutton debouncer for the tug-of-war game.
// Each channel synchronises its raw button through two flops and only lets
// the debounced level follow after DB_CYCLES consecutive disagreeing samples.
// A registered one-cycle press pulse marks each debounced rising edge.
// Channel 0 is left, channel 1 is right; they share no state.
module pb_debouncer #(
    parameter int unsigned DB_CYCLES = 8,
    parameter int unsigned CNT_W     = 4
) (
    input logic          clk,
    input logic          rst,
    pb_debouncer_if.slave pb
);

    typedef enum logic {
        STABLE,
        COUNTING
    } filt_state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       level;
    logic [1:0]       level_nxt;
    logic [1:0]       press;
    logic [1:0]       press_nxt;
    logic [CNT_W-1:0] cnt       [2];
    logic [CNT_W-1:0] cnt_nxt   [2];
    filt_state_t      state     [2];
    filt_state_t      state_nxt [2];

    assign raw = {pb.pbr_raw, pb.pbl_raw};

    // Two-flop synchroniser per channel; only s2 feeds the filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Filter state, stability counters, debounced levels and press pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            press <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i]   <= '0;
                state[i] <= STABLE;
            end
        end else begin
            level <= level_nxt;
            press <= press_nxt;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i]   <= cnt_nxt[i];
                state[i] <= state_nxt[i];
            end
        end
    end

    // Per-channel filter: count consecutive disagreements, flip on terminal count.
    always_comb begin
        level_nxt = level;
        press_nxt = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            unique case (state[i])
                STABLE: begin
                    // cnt is 0 here and DB_CYCLES >= 2, so the first
                    // disagreement can never be the terminal one.
                    if (s2[i] != level[i]) begin
                        state_nxt[i] = COUNTING;
                        cnt_nxt[i]   = CNT_W'(1);
                    end else begin
                        cnt_nxt[i]   = '0;
                    end
                end
                COUNTING: begin
                    if (s2[i] == level[i]) begin
                        state_nxt[i] = STABLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == TERM) begin
                        state_nxt[i] = STABLE;
                        cnt_nxt[i]   = '0;
                        level_nxt[i] = s2[i];
                        press_nxt[i] = s2[i];
                    end else begin
                        cnt_nxt[i]   = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = STABLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    assign pb.pbl       = level[0];
    assign pb.pbr       = level[1];
    assign pb.pbl_press = press[0];
    assign pb.pbr_press = press[1];

endmodule

// File: tb/tb_pb_debouncer.sv
// Self-checking bench for pb_debouncer: directed scenarios plus a random
// phase, all compared against a window-based behavioural model.
module tb_pb_debouncer;

    localparam int unsigned DB  = 8;
    localparam int unsigned LAT = DB + 2;

    logic clk;
    logic rst;

    pb_debouncer_if bus ();

    pb_debouncer #(
        .DB_CYCLES (DB),
        .CNT_W     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pb  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total;
    int unsigned n_pass;
    int unsigned n_fail;

    // Model: per channel, the raw value seen at each of the last LAT edges.
    // The debounced level flips once the oldest DB of those samples (the ones
    // that have already crossed the two-flop synchroniser) all oppose it.
    bit hist [2][LAT];
    bit m_lvl [2];
    bit m_prs [2];

    function automatic bit unanimous(input int ch, input bit v);
        for (int i = 0; i < int'(DB); i++)
            if (hist[ch][i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < int'(LAT); i++) hist[ch][i] = 1'b0;
            m_lvl[ch] = 1'b0;
            m_prs[ch] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit r [2];
        r[0] = bus.pbl_raw;
        r[1] = bus.pbr_raw;
        if (rst) begin
            model_reset();
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = 0; i < int'(LAT) - 1; i++) hist[ch][i] = hist[ch][i+1];
                hist[ch][LAT-1] = r[ch];
                m_prs[ch] = 1'b0;
                if (unanimous(ch, !m_lvl[ch])) begin
                    m_lvl[ch] = !m_lvl[ch];
                    m_prs[ch] = m_lvl[ch];
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model_pbl",       bus.pbl,       m_lvl[0]);
        check("model_pbr",       bus.pbr,       m_lvl[1]);
        check("model_pbl_press", bus.pbl_press, m_prs[0]);
        check("model_pbr_press", bus.pbr_press, m_prs[1]);
    endtask

    // One clock edge: update the model at the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse issued between edges.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_pbl"},       bus.pbl,       1'b0);
        check({tag, "_pbr"},       bus.pbr,       1'b0);
        check({tag, "_pbl_press"}, bus.pbl_press, 1'b0);
        check({tag, "_pbr_press"}, bus.pbr_press, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned l_press_cnt;
        int unsigned r_press_cnt;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.pbl_raw = 1'b0;
        bus.pbr_raw = 1'b0;
        model_reset();

        // Reset state
        repeat (3) step();
        check("reset_pbl",       bus.pbl,       1'b0);
        check("reset_pbr_press", bus.pbr_press, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while the left channel is mid-count, then requalify from scratch
        bus.pbl_raw = 1'b1;
        repeat (6) step();
        reset_pulse("rst_midcount");
        for (int k = 1; k <= int'(LAT) + 2; k++) begin
            step();
            check("requal_pbl",       bus.pbl,       k >= int'(LAT));
            check("requal_pbl_press", bus.pbl_press, k == int'(LAT));
        end

        // Release: level falls LAT edges after raw fall, no pulse
        bus.pbl_raw = 1'b0;
        for (int k = 1; k <= int'(LAT) + 2; k++) begin
            step();
            check("release_pbl",       bus.pbl,       k < int'(LAT));
            check("release_pbl_press", bus.pbl_press, 1'b0);
        end

        // Clean press on left; right stays idle
        bus.pbl_raw = 1'b1;
        for (int k = 1; k <= int'(LAT) + 4; k++) begin
            step();
            check("clean_pbl",       bus.pbl,       k >= int'(LAT));
            check("clean_pbl_press", bus.pbl_press, k == int'(LAT));
            check("clean_pbr",       bus.pbr,       1'b0);
        end
        bus.pbl_raw = 1'b0;
        repeat (LAT + 2) step();

        // Bounce rejection on right: 1x5, 0x2, 1x7, then 0
        begin
            int seq_len [4];
            bit seq_val [4];
            seq_len = '{5, 2, 7, int'(LAT) + 4};
            seq_val = '{1'b1, 1'b0, 1'b1, 1'b0};
            for (int s = 0; s < 4; s++) begin
                bus.pbr_raw = seq_val[s];
                for (int k = 0; k < seq_len[s]; k++) begin
                    step();
                    check("bounce_pbr",       bus.pbr,       1'b0);
                    check("bounce_pbr_press", bus.pbr_press, 1'b0);
                end
            end
        end

        // Bounce then settle: 1x3, 0x1, then steady 1
        bus.pbr_raw = 1'b1;
        repeat (3) step();
        bus.pbr_raw = 1'b0;
        step();
        bus.pbr_raw = 1'b1;
        for (int k = 1; k <= int'(LAT) + 3; k++) begin
            step();
            check("settle_pbr",       bus.pbr,       k >= int'(LAT));
            check("settle_pbr_press", bus.pbr_press, k == int'(LAT));
        end
        bus.pbr_raw = 1'b0;
        repeat (LAT + 2) step();

        // Simultaneous press
        bus.pbl_raw = 1'b1;
        bus.pbr_raw = 1'b1;
        for (int k = 1; k <= int'(LAT) + 3; k++) begin
            step();
            check("simul_pbl_press", bus.pbl_press, k == int'(LAT));
            check("simul_pbr_press", bus.pbr_press, k == int'(LAT));
        end

        // Reset while both held: exactly one new pulse per channel afterwards
        reset_pulse("rst_held");
        l_press_cnt = 0;
        r_press_cnt = 0;
        for (int k = 1; k <= int'(LAT) + 6; k++) begin
            step();
            check("held_pbl_press", bus.pbl_press, k == int'(LAT));
            if (bus.pbl_press === 1'b1) l_press_cnt++;
            if (bus.pbr_press === 1'b1) r_press_cnt++;
        end
        check("held_one_l_pulse", l_press_cnt == 1, 1'b1);
        check("held_one_r_pulse", r_press_cnt == 1, 1'b1);

        // Random bouncing on both channels
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) bus.pbl_raw = ~bus.pbl_raw;
            if ($urandom_range(0, 7) == 0) bus.pbr_raw = ~bus.pbr_raw;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pb_debouncer.md
Name: pb_debouncer

Overview:
- Two-channel pushbutton conditioner that sits directly upstream of the pushbutton latch in the tug-of-war game.
- Takes raw, bouncing, asynchronous left/right button inputs and synchronises each to the 500 Hz game clock. Filters contact bounce with a stability counter.
- Delivers clean debounced levels plus one-cycle press pulses to the latch/synchroniser path.
- Channels are identical and fully independent, so simultaneous presses reach tie detection in the same cycle.

Parameters:
- DB_CYCLES, 8, consecutive stable samples required before the debounced level changes. Legal range is 2..(2^CNT_W); 8 cycles at 500 Hz is 16 ms.
- CNT_W, 4, width of each channel's stability counter.

Ports:
- clk  input  1  game clock (500 Hz divided clock); all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- pbl_raw  input  1  raw left pushbutton, asynchronous, active-high when pressed.
- pbr_raw  input  1  raw right pushbutton, asynchronous, active-high when pressed.
- pbl  output  1  debounced left button level.
- pbr  output  1  debounced right button level.
- pbl_press  output  1  one-cycle pulse on debounced left rising edge.
- pbr_press  output  1  one-cycle pulse on debounced right rising edge.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- All outputs and internal registers are registered. Reset values are all 0: both sync stages, counters, pbl, pbr, pbl_press, pbr_press.
- Synchroniser: two flops per channel, raw -> s1 -> s2. Only s2 is used downstream. No combinational path from raw inputs to any output.
- Per-channel filter (shown for left; right is identical):
  - If s2 == pbl: cnt <= 0 and pbl holds.
  - If s2 != pbl and cnt < DB_CYCLES-1: cnt <= cnt+1 and pbl holds.
  - If s2 != pbl and cnt == DB_CYCLES-1: pbl <= s2 and cnt <= 0.
  - Effect: pbl changes after exactly DB_CYCLES consecutive clk edges of disagreement.
  - Any single agreeing sample restarts the count from 0. There is no partial credit.
- Filter states per channel: STABLE (cnt==0, s2==level) and COUNTING (s2!=level).
  - STABLE -> COUNTING when s2 differs.
  - COUNTING -> STABLE on agreement (level unchanged) or on terminal count (level toggles).
- Latency: a raw level held steady from edge 0 gives s2 valid after edge 2, and pbl changes at edge DB_CYCLES+2. With defaults that is edge 10 (20 ms).
- Press pulse:
  - pbl_press is registered and asserted high for exactly one clk cycle, the first cycle in which pbl is 1.
  - No pulse on release.
  - No further pulse while the button stays held.
- Glitches: a disagreement lasting DB_CYCLES-1 or fewer s2 samples produces no output change and no pulse.
- Simultaneous events: left and right share no state. Presses whose raw edges occur in the same cycle produce pbl_press and pbr_press in the same cycle.
- Release filtering is symmetric: pbl falls DB_CYCLES+2 edges after a steady raw release.
- Counter never exceeds DB_CYCLES-1, so there is no wrap-around.
- Reset mid-operation: asynchronously forces all outputs to 0 and discards partial counts. After rst deasserts, a button still held is re-qualified from scratch and yields exactly one press pulse DB_CYCLES+2 edges later.

Test Plan:
- Reset check: assert rst with pbl_raw=1 mid-count -> pbl, pbr, pbl_press, pbr_press = 0 immediately, without waiting for a clk edge.
- Clean press: with DB_CYCLES=8, raise pbl_raw before edge 0 and hold it -> pbl=1 after edge 10. pbl_press=1 only in the cycle after edge 10, then 0 while held. pbr and pbr_press stay 0.
- Bounce rejection: toggle pbr_raw 1 for 5 cycles, 0 for 2, 1 for 7, then 0 -> pbr and pbr_press never assert, and the counter returns to 0.
- Bounce then settle: 1 for 3 cycles, 0 for 1, then steady 1 -> pbr rises exactly DB_CYCLES+2 edges after the final rising raw edge, with a single pbr_press.
- Simultaneous press: pbl_raw and pbr_raw rise in the same cycle -> pbl_press and pbr_press are both high in the same single cycle.
- Release and reset mid-hold:
  - Release after a qualified press -> pbl falls 10 edges after the raw fall, with no pulse.
  - Pulse rst while held -> outputs go to 0, and exactly one new pbl_press occurs 10 edges after rst deasserts.
